// File: rtl/alarm_setter_pkg.sv
// Shared types, limits and BCD helpers for the alarm time setter.
package alarm_setter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EDIT_H = 2'd1,
    EDIT_M = 2'd2,
    COMMIT = 2'd3
  } state_t;

  typedef enum logic {
    TIME  = 1'b0,
    ALARM = 1'b1
  } target_t;

  localparam logic [6:0] HOUR_MAX = 7'd23;
  localparam logic [6:0] MIN_MAX  = 7'd59;

  localparam logic [1:0] FIELD_IDLE = 2'b00;
  localparam logic [1:0] FIELD_HOUR = 2'b01;
  localparam logic [1:0] FIELD_MIN  = 2'b10;

  function automatic logic [6:0] bcdToBin(input logic [3:0] tens, input logic [3:0] ones);
    return ({3'b000, tens} << 3) + ({3'b000, tens} << 1) + {3'b000, ones};
  endfunction

  function automatic logic [7:0] binToBcd(input logic [6:0] val);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(val / 7'd10);
    ones = 4'(val - ({3'b000, tens} * 7'd10));
    return {tens, ones};
  endfunction

  // Wrapping +/-1 over 0..max; BCD carries fall out of the binary round trip.
  function automatic logic [6:0] stepWrap(input logic [6:0] val, input logic [6:0] max,
                                          input logic up);
    if (up) begin
      return (val >= max) ? 7'd0 : val + 7'd1;
    end else begin
      return (val == 7'd0) ? max : val - 7'd1;
    end
  endfunction

endpackage

// File: rtl/alarm_time_setter_debounce.sv
// btn_debounce: 2-FF synchroniser, stability counter, registered rising-edge pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btnRaw,
  output logic rise,
  output logic level
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic syncMeta_r;
  logic syncOut_r;
  logic level_r;
  logic levelDly_r;
  logic rise_r;
  logic [CW-1:0] stableCnt_r;

  // Synchronise, accept a new level after DEBOUNCE_CYC stable samples, flag its rise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      syncMeta_r  <= 1'b0;
      syncOut_r   <= 1'b0;
      level_r     <= 1'b0;
      levelDly_r  <= 1'b0;
      rise_r      <= 1'b0;
      stableCnt_r <= '0;
    end else begin
      syncMeta_r <= btnRaw;
      syncOut_r  <= syncMeta_r;
      if (syncOut_r != level_r) begin
        if (stableCnt_r == CNT_LAST) begin
          level_r     <= syncOut_r;
          stableCnt_r <= '0;
        end else begin
          stableCnt_r <= stableCnt_r + CW'(1);
        end
      end else begin
        stableCnt_r <= '0;
      end
      levelDly_r <= level_r;
      rise_r     <= level_r & ~levelDly_r;
    end
  end

  assign rise  = rise_r;
  assign level = level_r;

endmodule

// File: rtl/alarm_time_setter.sv
// Button-driven HH:MM editor that loads the alarm clock's time or alarm registers.
// Optional hold-to-repeat on inc/dec: define ALARM_SETTER_AUTOREPEAT_EN.
module alarm_time_setter
  import alarm_setter_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 16,
  parameter int TIMEOUT_CYC  = 10000,
  parameter int BLINK_CYC    = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btnSetTime,
  input  logic       btnSetAlarm,
  input  logic       btnNext,
  input  logic       btnInc,
  input  logic       btnDec,
  input  logic [1:0] curHour1,
  input  logic [3:0] curHour0,
  input  logic [3:0] curMin1,
  input  logic [3:0] curMin0,
  output logic [1:0] hourIn1,
  output logic [3:0] hourIn0,
  output logic [3:0] minIn1,
  output logic [3:0] minIn0,
  output logic       ldTime,
  output logic       ldAlarm,
  output logic       editing,
  output logic [1:0] fieldSel,
  output logic       blink
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int BW = $clog2(BLINK_CYC + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_CYC - 1);

  logic [4:0] btnRaw_s;
  logic [4:0] rise_s;
  logic [4:0] level_s;
  logic       repInc_s;
  logic       repDec_s;

  assign btnRaw_s = {btnDec, btnInc, btnNext, btnSetAlarm, btnSetTime};

  for (genvar i = 0; i < 5; i++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn (
      .clk   (clk),
      .reset (reset),
      .btnRaw(btnRaw_s[i]),
      .rise  (rise_s[i]),
      .level (level_s[i])
    );
  end

`ifdef ALARM_SETTER_AUTOREPEAT_EN
  localparam int RW = $clog2(32 * DEBOUNCE_CYC + 2);
  localparam logic [RW-1:0] REP_FIRST  = RW'(32 * DEBOUNCE_CYC);
  localparam logic [RW-1:0] REP_RELOAD = RW'(24 * DEBOUNCE_CYC + 1);

  logic [RW-1:0] incHold_r;
  logic [RW-1:0] decHold_r;
  logic          repInc_r;
  logic          repDec_r;

  // Hold counters: first repeat after 32*DEBOUNCE_CYC held cycles, then every 8*DEBOUNCE_CYC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      incHold_r <= '0;
      decHold_r <= '0;
      repInc_r  <= 1'b0;
      repDec_r  <= 1'b0;
    end else begin
      repInc_r <= 1'b0;
      repDec_r <= 1'b0;
      if (level_s[3] && editing) begin
        if (incHold_r == REP_FIRST) begin
          repInc_r  <= 1'b1;
          incHold_r <= REP_RELOAD;
        end else begin
          incHold_r <= incHold_r + RW'(1);
        end
      end else begin
        incHold_r <= '0;
      end
      if (level_s[4] && editing) begin
        if (decHold_r == REP_FIRST) begin
          repDec_r  <= 1'b1;
          decHold_r <= REP_RELOAD;
        end else begin
          decHold_r <= decHold_r + RW'(1);
        end
      end else begin
        decHold_r <= '0;
      end
    end
  end

  assign repInc_s = repInc_r;
  assign repDec_s = repDec_r;
`else
  assign repInc_s = 1'b0;
  assign repDec_s = 1'b0;
`endif

  logic       stepUp_s;
  logic       stepDn_s;
  logic       doStep_s;
  logic       anyEvent_s;
  logic       cancel_s;
  logic [6:0] hourCur_s;
  logic [1:0] hourPre1_s;
  logic [3:0] hourPre0_s;
  logic [3:0] minPre1_s;
  logic [3:0] minPre0_s;
  logic [7:0] hourNext_s;
  logic [7:0] minNext_s;
  logic       unusedBits_s;

  assign stepUp_s   = rise_s[3] | repInc_s;
  assign stepDn_s   = rise_s[4] | repDec_s;
  assign doStep_s   = stepUp_s ^ stepDn_s;
  assign anyEvent_s = (|rise_s) | repInc_s | repDec_s;
  assign cancel_s   = rise_s[0] | rise_s[1];
  assign hourCur_s  = bcdToBin({2'b00, curHour1}, curHour0);
  assign hourNext_s = binToBcd(stepWrap(bcdToBin({2'b00, hourIn1}, hourIn0), HOUR_MAX, stepUp_s));
  assign minNext_s  = binToBcd(stepWrap(bcdToBin(minIn1, minIn0), MIN_MAX, stepUp_s));
  assign unusedBits_s = ^{level_s, hourNext_s[7:6]};

  // Preload values: an invalid or out-of-range live field becomes 00.
  always_comb begin
    hourPre1_s = 2'd0;
    hourPre0_s = 4'd0;
    minPre1_s  = 4'd0;
    minPre0_s  = 4'd0;
    if ((curHour0 <= 4'd9) && (hourCur_s <= HOUR_MAX)) begin
      hourPre1_s = curHour1;
      hourPre0_s = curHour0;
    end else begin
      hourPre1_s = 2'd0;
      hourPre0_s = 4'd0;
    end
    if ((curMin1 <= 4'd5) && (curMin0 <= 4'd9)) begin
      minPre1_s = curMin1;
      minPre0_s = curMin0;
    end else begin
      minPre1_s = 4'd0;
      minPre0_s = 4'd0;
    end
  end

  state_t        state_r;
  target_t       target_r;
  logic [TW-1:0] timeoutCnt_r;
  logic [BW-1:0] blinkCnt_r;

  // Edit FSM with registered buffer, load pulses and status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      target_r     <= TIME;
      hourIn1      <= 2'd0;
      hourIn0      <= 4'd0;
      minIn1       <= 4'd0;
      minIn0       <= 4'd0;
      ldTime       <= 1'b0;
      ldAlarm      <= 1'b0;
      editing      <= 1'b0;
      fieldSel     <= FIELD_IDLE;
      blink        <= 1'b0;
      timeoutCnt_r <= '0;
      blinkCnt_r   <= '0;
    end else begin
      ldTime  <= 1'b0;
      ldAlarm <= 1'b0;
      case (state_r)
        IDLE: begin
          editing  <= 1'b0;
          fieldSel <= FIELD_IDLE;
          blink    <= 1'b0;
          if (cancel_s) begin
            target_r     <= rise_s[0] ? TIME : ALARM;
            hourIn1      <= hourPre1_s;
            hourIn0      <= hourPre0_s;
            minIn1       <= minPre1_s;
            minIn0       <= minPre0_s;
            state_r      <= EDIT_H;
            editing      <= 1'b1;
            fieldSel     <= FIELD_HOUR;
            timeoutCnt_r <= '0;
            blinkCnt_r   <= '0;
          end else begin
            state_r <= IDLE;
          end
        end
        EDIT_H, EDIT_M: begin
          if (cancel_s || (!anyEvent_s && (timeoutCnt_r == TIMEOUT_LAST))) begin
            state_r  <= IDLE;
            editing  <= 1'b0;
            fieldSel <= FIELD_IDLE;
            blink    <= 1'b0;
          end else begin
            timeoutCnt_r <= anyEvent_s ? '0 : timeoutCnt_r + TW'(1);
            if (blinkCnt_r == BLINK_LAST) begin
              blinkCnt_r <= '0;
              blink      <= ~blink;
            end else begin
              blinkCnt_r <= blinkCnt_r + BW'(1);
            end
            if (rise_s[2]) begin
              if (state_r == EDIT_H) begin
                state_r  <= EDIT_M;
                fieldSel <= FIELD_MIN;
              end else begin
                state_r  <= COMMIT;
                editing  <= 1'b0;
                fieldSel <= FIELD_IDLE;
                blink    <= 1'b0;
                ldTime   <= (target_r == TIME);
                ldAlarm  <= (target_r == ALARM);
              end
            end else if (doStep_s) begin
              if (state_r == EDIT_H) begin
                hourIn1 <= hourNext_s[5:4];
                hourIn0 <= hourNext_s[3:0];
              end else begin
                minIn1 <= minNext_s[7:4];
                minIn0 <= minNext_s[3:0];
              end
            end else begin
              state_r <= state_r;
            end
          end
        end
        COMMIT: begin
          state_r <= IDLE;
        end
        default: begin
          state_r  <= IDLE;
          editing  <= 1'b0;
          fieldSel <= FIELD_IDLE;
          blink    <= 1'b0;
        end
      endcase
    end
  end

endmodule
